// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the P_Risc write-back stage
package wb_pkg;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - execute, data-memory and register-file signals of the write-back stage
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_ready;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            ex_is_load;
    logic [2:0]      ex_funct3;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic [4:0]      A3;
    logic            WE3;
    logic [XLEN-1:0] WD3;
    logic            pend_valid;
    logic [4:0]      pend_rd;
    logic            misalign;

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3,
        input  mem_rvalid, mem_rdata,
        output ex_ready, A3, WE3, WD3, pend_valid, pend_rd, misalign
    );

    modport master (
        output ex_valid, ex_rd, ex_result, ex_is_load, ex_funct3,
        output mem_rvalid, mem_rdata,
        input  ex_ready, A3, WE3, WD3, pend_valid, pend_rd, misalign
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects and sign/zero-extends load data from a raw memory word
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // pick the addressed byte and halfword; halfword ignores addr_lo[0]
    always_comb begin
        sel_byte = rdata[7:0];
        case (addr_lo)
            2'd0: sel_byte = rdata[7:0];
            2'd1: sel_byte = rdata[15:8];
            2'd2: sel_byte = rdata[23:16];
            2'd3: sel_byte = rdata[31:24];
            default: sel_byte = rdata[7:0];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // extend according to load type; unknown encodings behave as LW
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, sel_byte};
            F3_LH:   data = {{(XLEN-16){sel_half[15]}}, sel_half};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, sel_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - write-back stage owning the register-file write port (option: WB_MISALIGN_TRAP_EN)
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        CLK,
    input  logic        reset,
    wb_stage_if.slave   bus
);

    wb_state_e       state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      lo_q, lo_d;
    logic            we_q, we_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            mis_q, mis_d;
    logic            mis_c;
    logic [XLEN-1:0] ext_data;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata   (bus.mem_rdata),
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .data    (ext_data)
    );

`ifdef WB_MISALIGN_TRAP_EN
    // flag loads whose access crosses its natural alignment
    always_comb begin
        mis_c = 1'b0;
        case (f3_q)
            F3_LB, F3_LBU: mis_c = 1'b0;
            F3_LH, F3_LHU: mis_c = lo_q[0];
            default:       mis_c = (lo_q != 2'd0);
        endcase
    end
`else
    assign mis_c = 1'b0;
`endif

    // next state, load bookkeeping and the write to schedule for the next cycle
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        a3_d    = '0;
        wd_d    = '0;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    if (bus.ex_is_load) begin
                        state_d = S_WAIT_MEM;
                        rd_d    = bus.ex_rd;
                        f3_d    = bus.ex_funct3;
                        lo_d    = bus.ex_result[1:0];
                    end else if (bus.ex_rd != REG_ZERO) begin
                        we_d = 1'b1;
                        a3_d = bus.ex_rd;
                        wd_d = bus.ex_result;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d = S_IDLE;
                    mis_d   = mis_c;
                    if (!mis_c && (rd_q != REG_ZERO)) begin
                        we_d = 1'b1;
                        a3_d = rd_q;
                        wd_d = ext_data;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, pending-load fields and registered write port
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            a3_q    <= '0;
            wd_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            a3_q    <= a3_d;
            wd_q    <= wd_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.ex_ready   = (state_q == S_IDLE);
    assign bus.pend_valid = (state_q == S_WAIT_MEM);
    assign bus.pend_rd    = (state_q == S_WAIT_MEM) ? rd_q : REG_ZERO;
    assign bus.WE3        = we_q;
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd_q;
    assign bus.misalign   = mis_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        mis;
    } wr_t;

    logic CLK = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];

    logic [2:0]  ld_f3;
    logic [1:0]  ld_lo;
    logic [4:0]  ld_rd;

    wb_stage_if #(.XLEN(32)) bus ();

    wb_stage #(.XLEN(32)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (lo[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // every write-port event is matched against the oldest expectation
    always @(negedge CLK) begin
        if (!reset && (bus.WE3 || bus.misalign)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, bus.A3}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_we", {31'd0, bus.WE3}, {31'd0, e.we});
                check("sb_mis", {31'd0, bus.misalign}, {31'd0, e.mis});
                if (e.we) begin
                    check("sb_a3", {27'd0, bus.A3}, {27'd0, e.a3});
                    check("sb_wd3", bus.WD3, e.wd);
                end
            end
        end
    end

    task automatic send(input logic [4:0] rd, input logic [31:0] res, input logic is_ld, input logic [2:0] f3);
        check("ex_ready_at_send", {31'd0, bus.ex_ready}, 32'd1);
        bus.ex_valid   = 1'b1;
        bus.ex_rd      = rd;
        bus.ex_result  = res;
        bus.ex_is_load = is_ld;
        bus.ex_funct3  = f3;
        if (is_ld) begin
            ld_f3 = f3;
            ld_lo = res[1:0];
            ld_rd = rd;
        end else if (rd != 5'd0) begin
            exp_q.push_back('{we: 1'b1, a3: rd, wd: res, mis: 1'b0});
        end
        @(posedge CLK); #1;
        bus.ex_valid = 1'b0;
    endtask

    task automatic mem_resp(input int delay, input logic [31:0] data, input logic mis);
        for (int i = 0; i < delay; i++) begin
            check("pend_valid_wait", {31'd0, bus.pend_valid}, 32'd1);
            check("pend_rd_wait", {27'd0, bus.pend_rd}, {27'd0, ld_rd});
            check("ex_ready_wait", {31'd0, bus.ex_ready}, 32'd0);
            @(posedge CLK); #1;
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        if (mis)
            exp_q.push_back('{we: 1'b0, a3: ld_rd, wd: 32'd0, mis: 1'b1});
        else if (ld_rd != 5'd0)
            exp_q.push_back('{we: 1'b1, a3: ld_rd, wd: model_ext(ld_f3, ld_lo, data), mis: 1'b0});
        @(posedge CLK); #1;
        bus.mem_rvalid = 1'b0;
        check("ex_ready_after", {31'd0, bus.ex_ready}, 32'd1);
        check("pend_valid_after", {31'd0, bus.pend_valid}, 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) @(posedge CLK);
        #1;
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.ex_valid   = 1'b0;
        bus.ex_rd      = '0;
        bus.ex_result  = '0;
        bus.ex_is_load = 1'b0;
        bus.ex_funct3  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        ld_f3 = '0; ld_lo = '0; ld_rd = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_we3", {31'd0, bus.WE3}, 32'd0);
        check("rst_a3", {27'd0, bus.A3}, 32'd0);
        check("rst_wd3", bus.WD3, 32'd0);
        check("rst_pend_valid", {31'd0, bus.pend_valid}, 32'd0);
        check("rst_pend_rd", {27'd0, bus.pend_rd}, 32'd0);
        check("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        // single ALU write, latency one, one-cycle pulse
        send(5'd5, 32'h1234_5678, 1'b0, 3'b000);
        check("alu_we3_lat", {31'd0, bus.WE3}, 32'd1);
        check("alu_a3_lat", {27'd0, bus.A3}, 32'd5);
        @(posedge CLK); #1;
        check("alu_we3_drop", {31'd0, bus.WE3}, 32'd0);
        drain();

        // three back-to-back ALU writes
        send(5'd1, 32'hAAAA_0001, 1'b0, 3'b000);
        send(5'd2, 32'hBBBB_0002, 1'b0, 3'b000);
        check("b2b_we3_1", {31'd0, bus.WE3}, 32'd1);
        send(5'd3, 32'hCCCC_0003, 1'b0, 3'b000);
        check("b2b_we3_2", {31'd0, bus.WE3}, 32'd1);
        @(posedge CLK); #1;
        drain();

        // LB from byte 2, sign extended
        send(5'd7, 32'h0000_1002, 1'b1, 3'b000);
        mem_resp(3, 32'h0080_0000, 1'b0);
        drain();

        // LHU and LH from upper halfword
        send(5'd8, 32'h0000_2002, 1'b1, 3'b101);
        mem_resp(1, 32'h8001_0000, 1'b0);
        send(5'd9, 32'h0000_2002, 1'b1, 3'b001);
        mem_resp(0, 32'h8001_0000, 1'b0);
        drain();

        // LBU, LW and a few random byte loads
        send(5'd10, 32'h0000_0003, 1'b1, 3'b100);
        mem_resp(2, 32'hF1E2_D3C4, 1'b0);
        send(5'd11, 32'h0000_0100, 1'b1, 3'b010);
        mem_resp(1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send(5'd12 + 5'(i), {30'd0, 2'(i)}, 1'b1, 3'b000);
            mem_resp(1, $urandom, 1'b0);
        end
        drain();

        // rd 0 writes and stray response in IDLE produce nothing
        send(5'd0, 32'h5555_5555, 1'b0, 3'b000);
        check("rd0_we3", {31'd0, bus.WE3}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_1111;
        @(posedge CLK); #1;
        bus.mem_rvalid = 1'b0;
        check("stray_we3", {31'd0, bus.WE3}, 32'd0);
        drain();

        // reset during WAIT_MEM drops the load
        send(5'd20, 32'h0000_0000, 1'b1, 3'b010);
        check("pre_rst_pend", {31'd0, bus.pend_valid}, 32'd1);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        check("rst_wait_pend", {31'd0, bus.pend_valid}, 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h2222_2222;
        @(posedge CLK); #1;
        bus.mem_rvalid = 1'b0;
        check("rst_wait_we3", {31'd0, bus.WE3}, 32'd0);
        check("rst_wait_ready", {31'd0, bus.ex_ready}, 32'd1);
        drain();

`ifdef WB_MISALIGN_TRAP_EN
        send(5'd21, 32'h0000_0001, 1'b1, 3'b010);
        mem_resp(1, 32'h3333_3333, 1'b1);
        check("mis_pulse", {31'd0, bus.misalign}, 32'd1);
        check("mis_we3", {31'd0, bus.WE3}, 32'd0);
        @(posedge CLK); #1;
        check("mis_drop", {31'd0, bus.misalign}, 32'd0);
        send(5'd22, 32'h0000_0003, 1'b1, 3'b101);
        mem_resp(0, 32'h4444_4444, 1'b1);
`else
        send(5'd21, 32'h0000_0001, 1'b1, 3'b010);
        mem_resp(1, 32'h3333_3333, 1'b0);
        check("nomis_misalign", {31'd0, bus.misalign}, 32'd0);
        send(5'd22, 32'h0000_0003, 1'b1, 3'b101);
        mem_resp(0, 32'h8765_4321, 1'b0);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
